// File: rtl/vrased_mon_pkg.sv
// vrased_mon_pkg: shared FSM state encoding and violation-cause bit layout for vrased_mon
package vrased_mon_pkg;
  typedef enum logic [1:0] {OUTSIDE = 2'd0, INSIDE = 2'd1, KILL = 2'd2} state_t;
  localparam int CAUSE_W = 6;
  localparam int C_ATOM_ENTRY = 0;
  localparam int C_ATOM_EXIT = 1;
  localparam int C_IRQ = 2;
  localparam int C_DMA_SMEM = 3;
  localparam int C_CPU_REG = 4;
  localparam int C_DMA_REG = 5;
  typedef logic [CAUSE_W-1:0] cause_t;
endpackage

// File: rtl/vrased_mon_if.sv
// vrased_mon_if: observed CPU/DMA/irq bus plus monitor outputs; VRASED_MON_LOG_EN adds viol_cause/viol_cnt
interface vrased_mon_if;
  import vrased_mon_pkg::*;
  logic [15:0] pc, data_addr, dma_addr;
  logic data_en, data_wr, dma_en, irq, reset;
`ifdef VRASED_MON_LOG_EN
  cause_t viol_cause;
  logic [7:0] viol_cnt;
`endif
  modport master (
    output pc, data_en, data_wr, data_addr, dma_en, dma_addr, irq,
    input reset
`ifdef VRASED_MON_LOG_EN
    , input viol_cause, viol_cnt
`endif
  );
  modport slave (
    input pc, data_en, data_wr, data_addr, dma_en, dma_addr, irq,
    output reset
`ifdef VRASED_MON_LOG_EN
    , output viol_cause, viol_cnt
`endif
  );
endinterface

// File: rtl/vrased_region_chk.sv
// vrased_region_chk: inclusive [BASE, BASE+SIZE] hit test, compared at 17 bits so the top never wraps
module vrased_region_chk #(
  parameter logic [15:0] BASE = 16'h0000,
  parameter logic [15:0] SIZE = 16'h0000
) (
  input  logic [15:0] addr,
  output logic        hit
);
  assign hit = addr >= BASE && {1'b0, addr} <= {1'b0, BASE} + {1'b0, SIZE};
endmodule

// File: rtl/vrased_mon.sv
// vrased_mon: VRASED monitor FSM driving a held, registered MCU reset; VRASED_MON_LOG_EN adds cause/count logging
module vrased_mon
  import vrased_mon_pkg::*;
#(
  parameter int                 NREG          = 4,
  parameter logic [16*NREG-1:0] REG_BASE      = {16'hFFC0, 16'h1800, 16'h0B00, 16'h6A00},
  parameter logic [16*NREG-1:0] REG_SIZE      = {16'h001F, 16'h001F, 16'h0C00, 16'h001F},
  parameter logic [NREG-1:0]    REG_RO        = 4'b0001,
  parameter logic [15:0]        SMEM_BASE     = 16'hA100,
  parameter logic [15:0]        SMEM_LAST     = 16'hBFFE,
  parameter logic [15:0]        RESET_HANDLER = 16'h0000,
  parameter int                 HOLD_CYC      = 4
) (
  input logic         clk,
  input logic         rst,
  vrased_mon_if.slave bus
);
  state_t state, nxt;
  cause_t cause;
  logic [NREG-1:0] cpu_hit, dma_hit;
  logic [15:0] pc_prev;
  logic [7:0] hold;
  logic in_smem, reset_q;
  for (genvar i = 0; i < NREG; i++) begin : g_reg
    vrased_region_chk #(.BASE(REG_BASE[16*i+:16]), .SIZE(REG_SIZE[16*i+:16])) u_cpu (
      .addr(bus.data_addr), .hit(cpu_hit[i]));
    vrased_region_chk #(.BASE(REG_BASE[16*i+:16]), .SIZE(REG_SIZE[16*i+:16])) u_dma (
      .addr(bus.dma_addr), .hit(dma_hit[i]));
  end
  // classify this cycle's accesses into cause bits and pick the next monitor state
  always_comb begin
    in_smem = bus.pc >= SMEM_BASE && bus.pc <= SMEM_LAST;
    cause = '0;
    cause[C_ATOM_ENTRY] = state == OUTSIDE && in_smem && bus.pc != SMEM_BASE;
    cause[C_ATOM_EXIT] = state == INSIDE && !in_smem && pc_prev != SMEM_LAST;
    cause[C_IRQ] = state == INSIDE && bus.irq;
    cause[C_DMA_SMEM] = state == INSIDE && bus.dma_en;
    cause[C_CPU_REG] = state != KILL && bus.data_en &&
                       |(cpu_hit & ({NREG{!in_smem}} | ({NREG{bus.data_wr}} & REG_RO)));
    cause[C_DMA_REG] = state != KILL && bus.dma_en && |dma_hit;
    nxt = |cause ? KILL :
          state == OUTSIDE ? (bus.pc == SMEM_BASE ? INSIDE : OUTSIDE) :
          state == INSIDE ? (in_smem ? INSIDE : OUTSIDE) :
          (hold == 8'd0 && bus.pc == RESET_HANDLER) ? OUTSIDE : KILL;
  end
  // state, hold counter (reloaded while not killed), registered reset and previous pc
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= KILL;
      hold <= 8'(HOLD_CYC);
      reset_q <= 1'b1;
      pc_prev <= RESET_HANDLER;
    end else begin
      state <= nxt;
      hold <= state != KILL ? 8'(HOLD_CYC) : hold - {7'd0, hold != 8'd0};
      reset_q <= nxt == KILL;
      pc_prev <= state == KILL ? RESET_HANDLER : bus.pc;
    end
  assign bus.reset = reset_q;
`ifdef VRASED_MON_LOG_EN
  cause_t cause_q;
  logic [7:0] cnt_q;
  // capture the cause set and bump the saturating count on each entry into KILL
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cause_q <= '0;
      cnt_q <= '0;
    end else if (state != KILL && nxt == KILL) begin
      cause_q <= cause;
      cnt_q <= cnt_q + {7'd0, cnt_q != 8'hFF};
    end
  assign bus.viol_cause = cause_q;
  assign bus.viol_cnt = cnt_q;
`endif
endmodule
